// File: rtl/rf_writeback_arbiter.sv
// Round-robin writeback arbiter for the shared register-file write port,
// plus a destination-register busy scoreboard that drives the issue stall.
module rf_writeback_arbiter #(
   parameter int DATA_W  = 32,
   parameter int ADDR_W  = 5,
   parameter int NUM_REQ = 4
) (
   input  logic                        clk,
   input  logic                        reset,
   input  logic [NUM_REQ-1:0]          req_valid,
   input  logic [NUM_REQ*ADDR_W-1:0]   req_rd,
   input  logic [NUM_REQ*DATA_W-1:0]   req_data,
   output logic [NUM_REQ-1:0]          req_ready,
   output logic                        rf_we,
   output logic [ADDR_W-1:0]           rf_waddr,
   output logic [DATA_W-1:0]           rf_wdata,
   input  logic                        sb_set,
   input  logic [ADDR_W-1:0]           sb_rd,
   input  logic [ADDR_W-1:0]           rs1,
   input  logic [ADDR_W-1:0]           rs2,
   input  logic                        use_rs1,
   input  logic                        use_rs2,
   output logic                        stall,
   output logic [(2**ADDR_W)-1:0]      busy_vec
);
   localparam int NUM_REGS = 2**ADDR_W;
   localparam int PTR_W    = $clog2(NUM_REQ);

   typedef struct packed {
      logic [ADDR_W-1:0] rd;
      logic [DATA_W-1:0] data;
   } wb_req_t;

   logic [PTR_W-1:0]    rr_ptr;
   logic [PTR_W-1:0]    gnt_idx;
   logic [PTR_W-1:0]    cand;
   logic                gnt_found;
   logic                accept;
   wb_req_t             req_a [NUM_REQ];
   wb_req_t             gnt_req;
   logic [NUM_REGS-1:1] busy_q;

   for (genvar gi = 0; gi < NUM_REQ; gi++) begin : g_unpack
      assign req_a[gi] = '{rd: req_rd[gi*ADDR_W +: ADDR_W], data: req_data[gi*DATA_W +: DATA_W]};
   end

   // First valid requester at or after rr_ptr, wrapping.
   always_comb begin
      gnt_found = 1'b0;
      gnt_idx   = '0;
      cand      = '0;
      for (int k = 0; k < NUM_REQ; k++) begin
         cand = PTR_W'((int'(rr_ptr) + k) % NUM_REQ);
         if (!gnt_found && req_valid[cand]) begin
            gnt_found = 1'b1;
            gnt_idx   = cand;
         end
      end
   end

   assign accept  = gnt_found & ~reset;
   assign gnt_req = req_a[gnt_idx];

   always_comb begin
      req_ready = '0;
      if (accept) req_ready[gnt_idx] = 1'b1;
   end

   // Write port: x0 writes are accepted but never raise rf_we.
   always_ff @(posedge clk) begin
      if (reset) begin
         rf_we    <= 1'b0;
         rf_waddr <= '0;
         rf_wdata <= '0;
         rr_ptr   <= '0;
      end else begin
         rf_we <= 1'b0;
         if (accept) begin
            rr_ptr   <= PTR_W'((int'(gnt_idx) + 1) % NUM_REQ);
            rf_waddr <= gnt_req.rd;
            rf_wdata <= gnt_req.data;
            rf_we    <= |gnt_req.rd;
         end
      end
   end

   // Scoreboard: a same-cycle allocate beats the writeback clear.
   always_ff @(posedge clk) begin
      if (reset) begin
         busy_q <= '0;
      end else begin
         for (int r = 1; r < NUM_REGS; r++) begin
            if (sb_set && sb_rd == ADDR_W'(r))
               busy_q[r] <= 1'b1;
            else if (rf_we && rf_waddr == ADDR_W'(r))
               busy_q[r] <= 1'b0;
         end
      end
   end

   assign busy_vec = {busy_q, 1'b0};
   assign stall    = (use_rs1 & busy_vec[rs1]) | (use_rs2 & busy_vec[rs2]);

endmodule

// File: tb/tb_rf_writeback_arbiter.sv
// Directed table-driven bench for rf_writeback_arbiter with a short
// round-robin sequence under continuous contention.
module tb_rf_writeback_arbiter;
   logic         clk = 1'b0;
   logic         reset;
   logic [3:0]   req_valid;
   logic [19:0]  req_rd;
   logic [127:0] req_data;
   logic [3:0]   req_ready;
   logic         rf_we;
   logic [4:0]   rf_waddr;
   logic [31:0]  rf_wdata;
   logic         sb_set;
   logic [4:0]   sb_rd, rs1, rs2;
   logic         use_rs1, use_rs2;
   logic         stall;
   logic [31:0]  busy_vec;

   always #5 clk = ~clk;

   rf_writeback_arbiter dut (
      .clk(clk), .reset(reset),
      .req_valid(req_valid), .req_rd(req_rd), .req_data(req_data), .req_ready(req_ready),
      .rf_we(rf_we), .rf_waddr(rf_waddr), .rf_wdata(rf_wdata),
      .sb_set(sb_set), .sb_rd(sb_rd), .rs1(rs1), .rs2(rs2),
      .use_rs1(use_rs1), .use_rs2(use_rs2), .stall(stall), .busy_vec(busy_vec)
   );

   // Requester i drives rd = r+i and data = d+i.
   typedef struct {
      logic        rst;
      logic [3:0]  v;
      logic [4:0]  r;
      logic [31:0] d;
      logic        ss;
      logic [4:0]  sr, s1, s2;
      logic        u1, u2;
      logic [3:0]  e_rdy;
      logic        e_we;
      logic [4:0]  e_wa;
      logic [31:0] e_wd;
      logic        e_st;
      logic [31:0] e_busy;
   } vec_t;

   localparam int NV = 22;
   vec_t tbl [NV];
   int total = 0;
   int bad   = 0;

   task automatic chk(input string nm, input int row, input logic [31:0] act, input logic [31:0] exp);
      total++;
      if (act !== exp) begin
         bad++;
         $display("FAIL %s step %0d: got %h want %h", nm, row, act, exp);
      end
   endtask

   task automatic apply(input vec_t t);
      reset     = t.rst;
      req_valid = t.v;
      for (int i = 0; i < 4; i++) begin
         req_rd[i*5 +: 5]    = t.r + 5'(i);
         req_data[i*32 +: 32] = t.d + 32'(i);
      end
      sb_set  = t.ss;
      sb_rd   = t.sr;
      rs1     = t.s1;
      rs2     = t.s2;
      use_rs1 = t.u1;
      use_rs2 = t.u2;
   endtask

   initial begin
      //         rst  v     r      d              ss   sr     s1     s2     u1   u2    rdy   we   wa      wd             st   busy
      tbl[0]  = '{1'b1, 4'hF, 5'd3,  32'h0000_0100, 1'b1, 5'd7,  5'd7, 5'd0, 1'b1, 1'b0, 4'h0, 1'b0, 5'd0,  32'h0,         1'b0, 32'h0};
      tbl[1]  = '{1'b0, 4'h0, 5'd0,  32'h0,         1'b1, 5'd0,  5'd0, 5'd0, 1'b0, 1'b0, 4'h0, 1'b0, 5'd0,  32'h0,         1'b0, 32'h0};
      tbl[2]  = '{1'b0, 4'h8, 5'd2,  32'hDEAD_BEEC, 1'b0, 5'd0,  5'd0, 5'd0, 1'b0, 1'b0, 4'h8, 1'b0, 5'd0,  32'h0,         1'b0, 32'h0};
      tbl[3]  = '{1'b0, 4'hF, 5'd1,  32'h0000_1000, 1'b0, 5'd0,  5'd0, 5'd0, 1'b0, 1'b0, 4'h1, 1'b1, 5'd5,  32'hDEAD_BEEF, 1'b0, 32'h0};
      tbl[4]  = '{1'b0, 4'hF, 5'd1,  32'h0000_1000, 1'b0, 5'd0,  5'd0, 5'd0, 1'b0, 1'b0, 4'h2, 1'b1, 5'd1,  32'h0000_1000, 1'b0, 32'h0};
      tbl[5]  = '{1'b0, 4'hF, 5'd1,  32'h0000_1000, 1'b0, 5'd0,  5'd0, 5'd0, 1'b0, 1'b0, 4'h4, 1'b1, 5'd2,  32'h0000_1001, 1'b0, 32'h0};
      tbl[6]  = '{1'b0, 4'hF, 5'd1,  32'h0000_1000, 1'b0, 5'd0,  5'd0, 5'd0, 1'b0, 1'b0, 4'h8, 1'b1, 5'd3,  32'h0000_1002, 1'b0, 32'h0};
      tbl[7]  = '{1'b0, 4'h2, 5'd31, 32'h1234_4FFF, 1'b0, 5'd0,  5'd0, 5'd0, 1'b0, 1'b0, 4'h2, 1'b1, 5'd4,  32'h0000_1003, 1'b0, 32'h0};
      tbl[8]  = '{1'b0, 4'h0, 5'd0,  32'h0,         1'b1, 5'd7,  5'd0, 5'd0, 1'b0, 1'b0, 4'h0, 1'b0, 5'd0,  32'h1234_5000, 1'b0, 32'h0};
      tbl[9]  = '{1'b0, 4'h0, 5'd0,  32'h0,         1'b0, 5'd0,  5'd7, 5'd0, 1'b1, 1'b0, 4'h0, 1'b0, 5'd0,  32'h1234_5000, 1'b1, 32'h80};
      tbl[10] = '{1'b0, 4'h1, 5'd7,  32'h0000_0077, 1'b0, 5'd0,  5'd7, 5'd0, 1'b1, 1'b0, 4'h1, 1'b0, 5'd0,  32'h1234_5000, 1'b1, 32'h80};
      tbl[11] = '{1'b0, 4'h0, 5'd0,  32'h0,         1'b0, 5'd0,  5'd7, 5'd0, 1'b1, 1'b0, 4'h0, 1'b1, 5'd7,  32'h0000_0077, 1'b1, 32'h80};
      tbl[12] = '{1'b0, 4'h0, 5'd0,  32'h0,         1'b0, 5'd0,  5'd7, 5'd0, 1'b1, 1'b0, 4'h0, 1'b0, 5'd7,  32'h0000_0077, 1'b0, 32'h0};
      tbl[13] = '{1'b0, 4'h0, 5'd0,  32'h0,         1'b1, 5'd9,  5'd0, 5'd0, 1'b0, 1'b0, 4'h0, 1'b0, 5'd7,  32'h0000_0077, 1'b0, 32'h0};
      tbl[14] = '{1'b0, 4'h4, 5'd7,  32'h0000_0500, 1'b0, 5'd0,  5'd0, 5'd9, 1'b0, 1'b1, 4'h4, 1'b0, 5'd7,  32'h0000_0077, 1'b1, 32'h200};
      tbl[15] = '{1'b0, 4'h0, 5'd0,  32'h0,         1'b1, 5'd9,  5'd0, 5'd9, 1'b0, 1'b0, 4'h0, 1'b1, 5'd9,  32'h0000_0502, 1'b0, 32'h200};
      tbl[16] = '{1'b0, 4'h0, 5'd0,  32'h0,         1'b0, 5'd0,  5'd0, 5'd9, 1'b0, 1'b1, 4'h0, 1'b0, 5'd9,  32'h0000_0502, 1'b1, 32'h200};
      tbl[17] = '{1'b0, 4'h3, 5'd10, 32'h0000_0600, 1'b0, 5'd0,  5'd0, 5'd0, 1'b0, 1'b0, 4'h1, 1'b0, 5'd9,  32'h0000_0502, 1'b0, 32'h200};
      tbl[18] = '{1'b0, 4'h3, 5'd10, 32'h0000_0600, 1'b0, 5'd0,  5'd0, 5'd0, 1'b0, 1'b0, 4'h2, 1'b1, 5'd10, 32'h0000_0600, 1'b0, 32'h200};
      tbl[19] = '{1'b1, 4'hF, 5'd10, 32'h0000_0600, 1'b1, 5'd12, 5'd0, 5'd0, 1'b0, 1'b0, 4'h0, 1'b1, 5'd11, 32'h0000_0601, 1'b0, 32'h200};
      tbl[20] = '{1'b0, 4'hF, 5'd1,  32'h0,         1'b0, 5'd0,  5'd0, 5'd0, 1'b0, 1'b0, 4'h1, 1'b0, 5'd0,  32'h0,         1'b0, 32'h0};
      tbl[21] = '{1'b0, 4'h0, 5'd0,  32'h0,         1'b0, 5'd0,  5'd0, 5'd0, 1'b0, 1'b0, 4'h0, 1'b1, 5'd1,  32'h0,         1'b0, 32'h0};

      reset = 1'b1; req_valid = '0; req_rd = '0; req_data = '0;
      sb_set = 1'b0; sb_rd = '0; rs1 = '0; rs2 = '0; use_rs1 = 1'b0; use_rs2 = 1'b0;
      repeat (2) @(negedge clk);

      for (int n = 0; n < NV; n++) begin
         apply(tbl[n]);
         #2;
         chk("req_ready", n, 32'(req_ready), 32'(tbl[n].e_rdy));
         chk("rf_we",     n, 32'(rf_we),     32'(tbl[n].e_we));
         chk("rf_waddr",  n, 32'(rf_waddr),  32'(tbl[n].e_wa));
         chk("rf_wdata",  n, rf_wdata,       tbl[n].e_wd);
         chk("stall",     n, 32'(stall),     32'(tbl[n].e_st));
         chk("busy_vec",  n, busy_vec,       tbl[n].e_busy);
         @(negedge clk);
      end

      // Continuous contention from rr_ptr=1: grants must rotate 1,2,3,0,...
      for (int k = 0; k < 8; k++) begin
         int g, p;
         g = (1 + k) % 4;
         p = (k + 0) % 4;
         reset = 1'b0; req_valid = 4'hF; sb_set = 1'b0; use_rs1 = 1'b0; use_rs2 = 1'b0;
         for (int i = 0; i < 4; i++) begin
            req_rd[i*5 +: 5]     = 5'd4 + 5'(i);
            req_data[i*32 +: 32] = 32'h2000 + 32'(i);
         end
         #2;
         chk("rr_ready", 100 + k, 32'(req_ready), 32'(4'b0001 << g));
         chk("rr_we",    100 + k, 32'(rf_we),     (k == 0) ? 32'd0 : 32'd1);
         if (k > 0) begin
            chk("rr_waddr", 100 + k, 32'(rf_waddr), 32'(4 + p));
            chk("rr_wdata", 100 + k, rf_wdata,      32'h2000 + 32'(p));
         end
         @(negedge clk);
      end

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end
endmodule
